// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch prediction unit:
// 2-bit counter states, saturating update and the PC/history index hash.
package bp_pkg;

   typedef enum logic [1:0] {
      SN = 2'b00,
      WN = 2'b01,
      WT = 2'b10,
      ST = 2'b11
   } ctr_t;

   localparam logic [1:0] CTR_RESET = WN;

   // Widest index the hash must produce (BHT_ADDR_BITS tops out at 12).
   localparam int HASH_W = 12;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
      if (up)
         return (ctr == ST) ? ST : ctr + 2'd1;
      else
         return (ctr == SN) ? SN : ctr - 2'd1;
   endfunction

   // Word-aligned PC bits XOR history, masked to the table size.
   function automatic logic [HASH_W-1:0] bht_hash(input logic [31:0] pc,
                                                  input logic [HASH_W-1:0] ghr,
                                                  input int unsigned addr_bits);
      logic [HASH_W-1:0] mask;
      mask = HASH_W'((32'd1 << addr_bits) - 32'd1);
      return (HASH_W'(pc >> 2) ^ ghr) & mask;
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack: circular buffer where ptr names the next free slot
// and count saturates at the depth, so an overflowing push drops the oldest.
module bp_ras
   import bp_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_addr,
   output logic [31:0] top_addr,
   output logic        top_valid
);

   localparam int PW = $clog2(RAS_DEPTH);

   logic [PW-1:0] ptr_reg;
   logic [PW:0]   count_reg;
   logic [31:0]   entries [RAS_DEPTH];
   logic [PW-1:0] top_ptr;

   assign top_ptr   = ptr_reg - 1'b1;
   assign top_valid = (count_reg != '0);
   assign top_addr  = top_valid ? entries[top_ptr] : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg   <= '0;
         count_reg <= '0;
         for (int i = 0; i < RAS_DEPTH; i++)
            entries[i] <= 32'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               entries[ptr_reg] <= push_addr;
               ptr_reg          <= ptr_reg + 1'b1;
               if (count_reg != (PW+1)'(RAS_DEPTH))
                  count_reg <= count_reg + 1'b1;
            end
            2'b01: begin
               if (count_reg != '0) begin
                  ptr_reg   <= ptr_reg - 1'b1;
                  count_reg <= count_reg - 1'b1;
               end
            end
            // Call+return in one instruction swaps the top in place.
            2'b11: begin
               entries[top_ptr] <= push_addr;
               if (count_reg == '0)
                  count_reg <= (PW+1)'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Front-end predictor: bimodal/gshare 2-bit pattern table, speculative
// global history with mispredict repair, RAS and resolution statistics.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int BHT_ADDR_BITS = 5,
   parameter int GHR_BITS      = 0,
   parameter int RAS_DEPTH     = 4,
   localparam int GW           = (GHR_BITS > 0) ? GHR_BITS : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     p_valid,
   input  logic [31:0]              p_PC,
   input  logic                     p_isB,
   input  logic                     p_isCall,
   input  logic                     p_isRet,
   output logic                     p_taken,
   output logic [BHT_ADDR_BITS-1:0] p_index,
   output logic [GW-1:0]            p_ghr,
   output logic [31:0]              p_ras_addr,
   output logic                     p_ras_valid,
   input  logic                     u_valid,
   input  logic [BHT_ADDR_BITS-1:0] u_index,
   input  logic [GW-1:0]            u_ghr,
   input  logic                     u_taken,
   input  logic                     u_mispredict,
   output logic [31:0]              st_branches,
   output logic [31:0]              st_hits
);

   localparam int ENTRIES = 1 << BHT_ADDR_BITS;

   logic [1:0]        bht [ENTRIES];
   logic [GW-1:0]     ghr_reg, ghr_next;
   logic [HASH_W-1:0] ghr_ext;
   logic [31:0]       branches_reg, hits_reg;

   // With no history configured the register is held at zero permanently.
   function automatic logic [GW-1:0] ghr_shift(input logic [GW-1:0] g, input logic t);
      if (GHR_BITS == 0)
         return '0;
      return GW'({g, t});
   endfunction

   assign ghr_ext = (GHR_BITS > 0) ? HASH_W'(ghr_reg) : '0;
   assign p_index = BHT_ADDR_BITS'(bht_hash(p_PC, ghr_ext, BHT_ADDR_BITS));
   assign p_taken = bht[p_index][1];
   assign p_ghr   = ghr_reg;

   assign st_branches = branches_reg;
   assign st_hits     = hits_reg;

   // A repair outranks the decode shift: that decode slot is being flushed.
   always_comb begin
      ghr_next = ghr_reg;
      if (u_valid && u_mispredict)
         ghr_next = ghr_shift(u_ghr, u_taken);
      else if (p_valid && p_isB)
         ghr_next = ghr_shift(ghr_reg, p_taken);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++)
            bht[i] <= CTR_RESET;
      end else if (u_valid) begin
         bht[u_index] <= sat_update(bht[u_index], u_taken);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_reg      <= '0;
         branches_reg <= 32'd0;
         hits_reg     <= 32'd0;
      end else begin
         ghr_reg <= ghr_next;
         if (u_valid) begin
            branches_reg <= branches_reg + 32'd1;
            if (!u_mispredict)
               hits_reg <= hits_reg + 32'd1;
         end
      end
   end

   bp_ras #(
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (p_valid & p_isCall),
      .pop       (p_valid & p_isRet),
      .push_addr (p_PC + 32'd4),
      .top_addr  (p_ras_addr),
      .top_valid (p_ras_valid)
   );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit (gshare, 3-bit history): directed scenarios
// plus random traffic, all checked against a list/array model every cycle.
module tb_branch_predict_unit;

   localparam int AB = 5;
   localparam int GB = 3;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          p_valid, p_isB, p_isCall, p_isRet;
   logic [31:0]   p_PC;
   logic          p_taken;
   logic [AB-1:0] p_index;
   logic [GB-1:0] p_ghr;
   logic [31:0]   p_ras_addr;
   logic          p_ras_valid;
   logic          u_valid, u_taken, u_mispredict;
   logic [AB-1:0] u_index;
   logic [GB-1:0] u_ghr;
   logic [31:0]   st_branches, st_hits;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: plain integers, a list for the stack.
   int unsigned m_cnt [32];
   int unsigned m_ghr;
   logic [31:0] m_ras [$];
   logic [31:0] m_br, m_hit;

   branch_predict_unit #(
      .BHT_ADDR_BITS (AB),
      .GHR_BITS      (GB),
      .RAS_DEPTH     (RD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .p_valid      (p_valid),
      .p_PC         (p_PC),
      .p_isB        (p_isB),
      .p_isCall     (p_isCall),
      .p_isRet      (p_isRet),
      .p_taken      (p_taken),
      .p_index      (p_index),
      .p_ghr        (p_ghr),
      .p_ras_addr   (p_ras_addr),
      .p_ras_valid  (p_ras_valid),
      .u_valid      (u_valid),
      .u_index      (u_index),
      .u_ghr        (u_ghr),
      .u_taken      (u_taken),
      .u_mispredict (u_mispredict),
      .st_branches  (st_branches),
      .st_hits      (st_hits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_cnt[i] = 1;
      m_ghr = 0;
      m_ras.delete();
      m_br  = 0;
      m_hit = 0;
   endtask

   function automatic int unsigned m_index(input logic [31:0] pc);
      return ((pc >> 2) ^ m_ghr) & 31;
   endfunction

   task automatic model_step();
      int unsigned idx;
      int unsigned pt;
      logic [31:0] ra;
      idx = m_index(p_PC);
      pt  = (m_cnt[idx] >= 2) ? 1 : 0;
      ra  = p_PC + 32'd4;
      if (u_valid) begin
         if (u_taken && m_cnt[u_index] < 3) m_cnt[u_index]++;
         if (!u_taken && m_cnt[u_index] > 0) m_cnt[u_index]--;
         m_br++;
         if (!u_mispredict) m_hit++;
      end
      if (u_valid && u_mispredict)
         m_ghr = ((int'(u_ghr) * 2) + int'(u_taken)) % 8;
      else if (p_valid && p_isB)
         m_ghr = ((m_ghr * 2) + pt) % 8;
      if (p_valid) begin
         if (p_isCall && p_isRet) begin
            if (m_ras.size() == 0) m_ras.push_back(ra);
            else m_ras[m_ras.size()-1] = ra;
         end else if (p_isCall) begin
            m_ras.push_back(ra);
            if (m_ras.size() > RD) void'(m_ras.pop_front());
         end else if (p_isRet) begin
            if (m_ras.size() != 0) void'(m_ras.pop_back());
         end
      end
   endtask

   task automatic check_outputs();
      int unsigned idx;
      logic [31:0] exp_addr;
      idx = m_index(p_PC);
      exp_addr = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 32'd0;
      chk("p_taken", 32'(p_taken), (m_cnt[idx] >= 2) ? 32'd1 : 32'd0);
      chk("p_index", 32'(p_index), idx);
      chk("p_ghr", 32'(p_ghr), m_ghr);
      chk("p_ras_valid", 32'(p_ras_valid), (m_ras.size() != 0) ? 32'd1 : 32'd0);
      chk("p_ras_addr", p_ras_addr, exp_addr);
      chk("st_branches", st_branches, m_br);
      chk("st_hits", st_hits, m_hit);
   endtask

   // Per-cycle compare at the falling edge, model advance at the rising edge.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (reset) model_reset();
         check_outputs();
         @(posedge clk);
         if (!reset) model_step();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p_valid = 0; p_isB = 0; p_isCall = 0; p_isRet = 0;
      u_valid = 0; u_taken = 0; u_mispredict = 0; u_index = '0; u_ghr = '0;
   endtask

   initial begin
      logic [31:0] pops [4];
      pops[0] = 32'h504; pops[1] = 32'h404; pops[2] = 32'h304; pops[3] = 32'h204;
      idle();
      p_PC  = 32'h0;
      reset = 1;
      repeat (2) step();
      reset = 0;

      // Reset prediction at 0x40.
      p_PC = 32'h40; p_isB = 1;
      #1;
      chk("rst_taken", 32'(p_taken), 32'd0);
      chk("rst_index", 32'(p_index), 32'd16);
      chk("rst_ras_valid", 32'(p_ras_valid), 32'd0);

      // Counter saturation.
      u_valid = 1; u_index = 5'd16; u_taken = 1;
      repeat (2) step();
      u_valid = 0; #1;
      chk("sat_two_taken", 32'(p_taken), 32'd1);
      u_valid = 1;
      repeat (5) step();
      u_taken = 0;
      step();
      u_valid = 0; #1;
      chk("sat_one_nt", 32'(p_taken), 32'd1);
      u_valid = 1;
      step();
      u_valid = 0; #1;
      chk("sat_two_nt", 32'(p_taken), 32'd0);

      // Gshare history and repair.
      p_PC = 32'h80; p_valid = 1; p_isB = 1;
      repeat (3) step();
      p_valid = 0; #1;
      chk("ghr_three_nt", 32'(p_ghr), 32'd0);
      p_valid = 1; u_valid = 1; u_mispredict = 1; u_ghr = 3'b101; u_taken = 1; u_index = 5'd3;
      step();
      idle(); #1;
      chk("ghr_repair", 32'(p_ghr), 32'h3);

      // RAS overflow.
      for (int i = 1; i <= 5; i++) begin
         p_PC = 32'(i) * 32'h100; p_valid = 1; p_isCall = 1;
         step();
      end
      p_isCall = 0; p_isRet = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("ras_pop_addr", p_ras_addr, pops[i]);
         step();
      end
      p_valid = 0; #1;
      chk("ras_empty", 32'(p_ras_valid), 32'd0);
      p_valid = 1;
      step();
      p_valid = 0; #1;
      chk("ras_extra_pop_valid", 32'(p_ras_valid), 32'd0);
      chk("ras_extra_pop_addr", p_ras_addr, 32'd0);

      // Call+ret in one cycle.
      p_PC = 32'h100; p_valid = 1; p_isRet = 0; p_isCall = 1;
      step();
      p_PC = 32'h800; p_isRet = 1;
      step();
      idle(); #1;
      chk("callret_addr", p_ras_addr, 32'h804);
      chk("callret_valid", 32'(p_ras_valid), 32'd1);
      p_valid = 1; p_isRet = 1;
      step();
      idle(); #1;
      chk("callret_count", 32'(p_ras_valid), 32'd0);

      // Statistics.
      reset = 1;
      step();
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         u_valid = 1; u_index = 5'($urandom); u_taken = 1'($urandom);
         u_mispredict = (i % 3 == 2);
         step();
      end
      idle(); #1;
      chk("st_branches10", st_branches, 32'd10);
      chk("st_hits7", st_hits, 32'd7);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         p_valid      = ($urandom_range(0, 3) != 0);
         p_PC         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         p_isB        = 1'($urandom);
         p_isCall     = ($urandom_range(0, 3) == 0);
         p_isRet      = ($urandom_range(0, 3) == 0);
         u_valid      = 1'($urandom);
         u_index      = 5'($urandom);
         u_ghr        = 3'($urandom);
         u_taken      = 1'($urandom);
         u_mispredict = ($urandom_range(0, 3) == 0);
         step();
      end
      idle();

      // Asynchronous reset mid-cycle.
      u_valid = 1; u_mispredict = 1; u_ghr = '0; u_taken = 0; u_index = '0;
      step();
      u_mispredict = 0; u_index = 5'd16; u_taken = 1;
      repeat (3) step();
      idle();
      p_PC = 32'h40; p_valid = 1; p_isCall = 1;
      step();
      idle(); #1;
      chk("pre_rst_taken", 32'(p_taken), 32'd1);
      chk("pre_rst_ras", 32'(p_ras_valid), 32'd1);
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("arst_taken", 32'(p_taken), 32'd0);
      chk("arst_ras_valid", 32'(p_ras_valid), 32'd0);
      chk("arst_ras_addr", p_ras_addr, 32'd0);
      chk("arst_ghr", 32'(p_ghr), 32'd0);
      chk("arst_branches", st_branches, 32'd0);
      chk("arst_hits", st_hits, 32'd0);
      repeat (2) step();
      reset = 0;
      u_valid = 1; u_index = 5'd16; u_taken = 1;
      step();
      idle(); #1;
      chk("arst_weak_nt", 32'(p_taken), 32'd1);
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the core's single-table 2-bit BHT: a standalone front-end prediction block instantiated beside the decode stage of the pipelined RV32I core.
- Provides bimodal or gshare direction prediction and a return-address stack (RAS) for JALR returns.
- Resolution arrives from execute. The block repairs speculative global history on mispredict and keeps hit/branch statistics counters.

Parameters:
- BHT_ADDR_BITS, 5, log2 of pattern-table entries (table has 1<<BHT_ADDR_BITS 2-bit counters); legal 2..12.
- GHR_BITS, 0, global-history length; 0 selects pure bimodal; legal 0..BHT_ADDR_BITS.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- p_valid  in  1  decode slot holds a real, non-stalled, non-flushed instruction this cycle.
- p_PC  in  32  PC of decode instruction.
- p_isB  in  1  decode instruction is B-type.
- p_isCall  in  1  JAL/JALR with rd in {x1,x5}.
- p_isRet  in  1  JALR with rs1 in {x1,x5} and rd=x0.
- p_taken  out  1  predicted direction = MSB of indexed counter.
- p_index  out  BHT_ADDR_BITS  table index, carried down pipe to execute.
- p_ghr  out  max(GHR_BITS,1)  GHR value before this prediction's shift, carried down pipe.
- p_ras_addr  out  32  top-of-stack return target.
- p_ras_valid  out  1  RAS non-empty.
- u_valid  in  1  execute resolved a B-type this cycle.
- u_index  in  BHT_ADDR_BITS  p_index carried with that branch.
- u_ghr  in  max(GHR_BITS,1)  p_ghr carried with that branch.
- u_taken  in  1  actual outcome.
- u_mispredict  in  1  u_taken != predicted direction; qualified by u_valid.
- st_branches  out  32  resolved branch count.
- st_hits  out  32  correctly predicted count.

Behaviour:
- Reset (async assert, sync-safe deassert): every counter = 2'b01 (weakly not-taken), GHR=0, RAS pointer=0, RAS count=0, RAS entries=0, st_*=0.
- Reset outputs: p_taken=0, p_ras_valid=0, p_ras_addr=0.
- Index = p_PC[BHT_ADDR_BITS+1:2] XOR zero-extended GHR. With GHR_BITS=0 there is no XOR and p_ghr=0.
- p_taken, p_index, p_ghr and p_ras_* are combinational from p_PC and current state: zero-cycle latency, consumed the same cycle as decode.
- Counter update, on u_valid: table[u_index] <= saturating inc if u_taken, else dec. 00 stays at 00 on dec; 11 stays at 11 on inc.
- Same-cycle read/write of the same index: prediction sees the pre-update value (no bypass). The write lands at the edge.
- Speculative GHR:
  - On p_valid & p_isB: GHR <= {GHR[GHR_BITS-2:0], p_taken}.
  - On u_valid & u_mispredict: GHR <= {u_ghr[GHR_BITS-2:0], u_taken}.
  - If both occur in one cycle, the repair wins (the decode instruction is being flushed).
- RAS:
  - Circular buffer; ptr addresses the next free slot; top = entry[ptr-1].
  - p_valid & p_isCall only: push p_PC+4 (32-bit wrap); ptr+1 mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry.
  - p_valid & p_isRet only: pop; ptr-1, count-1. If count=0 there is no change.
  - Call and ret together: top entry is replaced by p_PC+4; ptr and count unchanged (count becomes 1 if it was 0).
  - p_ras_valid = (count != 0); p_ras_addr = top when valid, else 0.
  - RAS is not repaired on mispredict; a wrong-path call/ret may corrupt it. This is a performance effect only, since the core verifies JALR targets in execute.
- Statistics:
  - st_branches += 1 on u_valid.
  - st_hits += 1 on u_valid & !u_mispredict.
  - Both wrap at 2^32.
- Inputs with p_valid=0 cause no state change. u_mispredict without u_valid is ignored.

Decomposition:
- Package bp_pkg:
  - Counter encoding constants: SN=2'b00, WN=2'b01, WT=2'b10, ST=2'b11.
  - Reset value WN.
  - Saturating inc/dec function.
  - Index-hash function.
- One sub-module, bp_ras: ptr/count/entries plus push/pop logic, parametrised by RAS_DEPTH.
- The top level holds the table, GHR and statistics.

Test Plan:
- Reset, then BHT_ADDR_BITS=5, GHR_BITS=0, p_PC=0x40, p_isB=1 -> p_taken=0, p_index=16, p_ras_valid=0.
- Counter saturation: two u_valid, u_index=16, u_taken=1 -> next predict at 0x40 gives p_taken=1. Five more taken updates, then one not-taken -> p_taken stays 1. A second not-taken -> p_taken=0.
- gshare repair: GHR_BITS=3; three predicted branches with p_taken=0 -> GHR=000. Then u_mispredict with u_ghr=3'b101, u_taken=1 -> GHR=3'b011. A same-cycle p_isB is ignored for GHR.
- RAS overflow, RAS_DEPTH=4: calls at 0x100,0x200,0x300,0x400,0x500 -> pops return 0x504,0x404,0x304,0x204, then p_ras_valid=0. A further pop leaves state unchanged.
- Call+ret same cycle at p_PC=0x800 with top 0x104 -> top becomes 0x804, count unchanged.
- Stats and async reset: 10 updates with 3 mispredicts -> st_branches=10, st_hits=7. Assert reset mid-cycle -> all outputs 0 and counters read WN immediately, without waiting for a clock edge.
